// File: rtl/rv32i_types.sv
// Shared types for the RV32I memory-port arbiter: FSM states, grant side and
// the latched physical request.
package rv32i_types;

  localparam int unsigned ARB_ADDR_W = 32;
  localparam int unsigned ARB_DATA_W = 32;
  localparam int unsigned ARB_MBE_W  = ARB_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SERVE_I = 2'b01,
    SERVE_D = 2'b10
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } arb_side_t;

  typedef struct packed {
    logic                  read;
    logic                  write;
    logic [ARB_ADDR_W-1:0] address;
    logic [ARB_DATA_W-1:0] wdata;
    logic [ARB_MBE_W-1:0]  mbe;
  } arb_req_t;

  // A data request with both read and write raised is treated as a write.
  function automatic logic [1:0] arb_dkind(input logic rd, input logic wr);
    return {rd & ~wr, wr};
  endfunction

endpackage

// File: rtl/mem_port_arbiter_prio.sv
// Combinational grant selection between fetch and data requesters.
// `ARB_ROUND_ROBIN_EN selects alternating priority on ties; otherwise D wins.
module mem_port_arbiter_prio
  import rv32i_types::*;
(
  input  logic      i_pend_i,
  input  logic      d_pend_i,
  input  arb_side_t last_grant_i,
  output logic      grant_valid_o,
  output arb_side_t grant_side_o
);

  // Pick the side to serve from the pending requests
  always_comb begin
    grant_valid_o = i_pend_i | d_pend_i;
    grant_side_o  = GRANT_I;
    if (i_pend_i && d_pend_i) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_side_o = (last_grant_i == GRANT_D) ? GRANT_I : GRANT_D;
`else
      grant_side_o = GRANT_D;
`endif
    end else if (d_pend_i) begin
      grant_side_o = GRANT_D;
    end else begin
      grant_side_o = GRANT_I;
    end
  end

`ifndef ARB_ROUND_ROBIN_EN
  logic unused_last_grant_s;
  assign unused_last_grant_s = last_grant_i;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one physical memory port between instruction fetch and data access.
// Optional `ARB_ROUND_ROBIN_EN alternates priority on simultaneous requests.
module mem_port_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                imem_read,
  input  logic [ADDR_W-1:0]   imem_address,
  output logic [DATA_W-1:0]   imem_rdata,
  output logic                imem_resp,
  input  logic                dmem_read,
  input  logic                dmem_write,
  input  logic [ADDR_W-1:0]   dmem_address,
  input  logic [DATA_W-1:0]   dmem_wdata,
  input  logic [DATA_W/8-1:0] dmem_mbe,
  output logic [DATA_W-1:0]   dmem_rdata,
  output logic                dmem_resp,
  output logic                pmem_read,
  output logic                pmem_write,
  output logic [ADDR_W-1:0]   pmem_address,
  output logic [DATA_W-1:0]   pmem_wdata,
  output logic [DATA_W/8-1:0] pmem_mbe,
  input  logic [DATA_W-1:0]   pmem_rdata,
  input  logic                pmem_resp
);

  localparam int unsigned MBE_W = DATA_W / 8;

  arb_state_t state_q;
  arb_req_t   req_q;
  arb_req_t   req_i_d;
  arb_req_t   req_d_d;
  logic       grant_valid_s;
  arb_side_t  grant_side_s;
  arb_side_t  last_grant_s;

  mem_port_arbiter_prio u_prio (
    .i_pend_i      (imem_read),
    .d_pend_i      (dmem_read | dmem_write),
    .last_grant_i  (last_grant_s),
    .grant_valid_o (grant_valid_s),
    .grant_side_o  (grant_side_s)
  );

  // Candidate requests from each side, ready to be latched on a grant
  always_comb begin
    req_i_d                     = '0;
    req_i_d.read                = 1'b1;
    req_i_d.address[ADDR_W-1:0] = imem_address;
    req_i_d.mbe                 = '1;

    req_d_d                            = '0;
    {req_d_d.read, req_d_d.write}      = arb_dkind(dmem_read, dmem_write);
    req_d_d.address[ADDR_W-1:0]        = dmem_address;
    req_d_d.wdata[DATA_W-1:0]          = dmem_wdata;
    req_d_d.mbe[MBE_W-1:0]             = dmem_mbe;
  end

  // Grant FSM; the latched request doubles as the registered pmem outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_valid_s) begin
            state_q <= (grant_side_s == GRANT_D) ? SERVE_D : SERVE_I;
            req_q   <= (grant_side_s == GRANT_D) ? req_d_d : req_i_d;
          end else begin
            state_q <= IDLE;
            req_q   <= '0;
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            state_q <= IDLE;
            req_q   <= '0;
          end else begin
            state_q <= state_q;
            req_q   <= req_q;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= '0;
        end
      endcase
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  arb_side_t last_grant_q;

  // Remember which side was granted most recently for tie-breaking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= GRANT_I;
    end else if ((state_q == IDLE) && grant_valid_s) begin
      last_grant_q <= grant_side_s;
    end else begin
      last_grant_q <= last_grant_q;
    end
  end

  assign last_grant_s = last_grant_q;
`else
  assign last_grant_s = GRANT_I;
`endif

  assign pmem_read    = req_q.read;
  assign pmem_write   = req_q.write;
  assign pmem_address = req_q.address[ADDR_W-1:0];
  assign pmem_wdata   = req_q.wdata[DATA_W-1:0];
  assign pmem_mbe     = req_q.mbe[MBE_W-1:0];

  // Completion is routed only to the side currently being served
  assign imem_resp  = (state_q == SERVE_I) & pmem_resp;
  assign dmem_resp  = (state_q == SERVE_D) & pmem_resp;
  assign imem_rdata = imem_resp ? pmem_rdata : {DATA_W{1'b0}};
  assign dmem_rdata = dmem_resp ? pmem_rdata : {DATA_W{1'b0}};

endmodule
